pipeline_controller: RTL
========================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have: CLK  input  1  clock, rising-edge active.
REQ-002 SHALL have: nRST  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: ihit  input  1  instruction fetch completes this cycle.
REQ-004 SHALL have: dhit  input  1  data access completes this cycle.
REQ-005 SHALL have: mem_dREN, mem_dWEN  input  1 each  data read/write pending in memory stage.
REQ-006 SHALL have: mem_branch_taken, mem_jump, mem_halt  input  1 each  control outcome resolved in memory stage.
REQ-007 SHALL have: ex_dREN  input  1  instruction in execute stage is a load.
REQ-008 SHALL have: ex_wsel, id_rs, id_rt  input  5 each  load destination; decode-stage source registers.
REQ-009 SHALL have: pc_en  output  1  PC update enable.
REQ-010 SHALL have: fetch_en, fetch_flush, decode_en, decode_flush, execute_en, execute_flush, memory_en, memory_flush  output  1 each  per-latch enable/flush; a latch clears only when en and flush are both 1.
REQ-011 SHALL have: halted  output  1  sticky halt indication (registered).
REQ-012 SHALL have: dstall_count  output  16  data-wait cycles counted since reset.

Function
REQ-013 SHALL implement FSM states RUN, DWAIT, HALT; state, halted and dstall_count registered; all en/flush/pc_en outputs combinational from state and inputs (zero latency).
REQ-014 SHALL define mem_busy = (mem_dREN | mem_dWEN) & !dhit; ld_use = ex_dREN & ex_wsel != 0 & (ex_wsel == id_rs | ex_wsel == id_rt).
REQ-015 SHALL apply, in RUN/DWAIT, priority: mem_busy > mem_halt > branch/jump > ld_use > !ihit > normal.
REQ-016 mem_busy: all en = 0, all flush = 0, pc_en = 0; next state DWAIT; dstall_count += 1, saturating at 0xFFFF.
REQ-017 DWAIT with dhit: leave to RUN (or HALT per REQ-018) and drive outputs for the rule of next-highest priority that applies in the same cycle.
REQ-018 mem_halt (not mem_busy): memory_en = 1, memory_flush = 0; fetch/decode/execute en = 1 with flush = 1; pc_en = 0; next state HALT.
REQ-019 mem_branch_taken | mem_jump: pc_en = 1; fetch, decode, execute en = 1 with flush = 1; memory_en = 1, memory_flush = 0.
REQ-020 ld_use: pc_en = 0; fetch_en = 0; decode_en = 1, decode_flush = 1 (bubble); execute_en = memory_en = 1, no flush.
REQ-021 !ihit: pc_en = 0; fetch_en = 1, fetch_flush = 1 (bubble); decode/execute/memory en = 1, no flush.
REQ-022 normal: pc_en = 1; all en = 1; all flush = 0.
REQ-023 HALT: all en/flush/pc_en = 0; halted = 1; state held until reset; all other inputs ignored.
REQ-024 halted SHALL rise on the clock edge entering HALT.
REQ-025 ld_use SHALL be ignored when ex_wsel = 0.

Reset
REQ-026 nRST low SHALL asynchronously set state RUN, halted 0, dstall_count 0.
REQ-027 While nRST low, all en, flush and pc_en SHALL be 0.
REQ-028 Reset asserted in DWAIT or HALT SHALL return to RUN; first post-reset cycle follows RUN rules.

Verification
REQ-029 ihit=1, no hazards -> pc_en=1, all en=1, all flush=0, state RUN.
REQ-030 mem_dREN=1, dhit=0 for 3 cycles then dhit=1 -> all en=0 for 3 cycles; dstall_count=3; on dhit cycle all en=1; state RUN.
REQ-031 ex_dREN=1, ex_wsel=5, id_rt=5 -> pc_en=0, fetch_en=0, decode_en=1/decode_flush=1; ex_wsel=0, id_rs=0 -> no stall.
REQ-032 mem_branch_taken=1 with ld_use and ihit=0 -> pc_en=1, fetch/decode/execute flushed, memory_en=1, memory_flush=0.
REQ-033 mem_halt=1 with mem_dWEN=1, dhit=0 -> freeze; dhit=1 next cycle -> memory_en=1, then HALT, halted=1, all en=0 thereafter; nRST pulse -> halted=0, RUN.

Source files
------------

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: derives per-latch enable/flush and PC enable
// from memory-stage status, control outcomes and load-use hazards, tracks a
// sticky halt state and counts data-wait cycles.
module pipeline_controller (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dREN,
    input  logic        mem_dWEN,
    input  logic        mem_branch_taken,
    input  logic        mem_jump,
    input  logic        mem_halt,
    input  logic        ex_dREN,
    input  logic [4:0]  ex_wsel,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    output logic        pc_en,
    output logic        fetch_en,
    output logic        fetch_flush,
    output logic        decode_en,
    output logic        decode_flush,
    output logic        execute_en,
    output logic        execute_flush,
    output logic        memory_en,
    output logic        memory_flush,
    output logic        halted,
    output logic [15:0] dstall_count
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        halted_q;
    logic [15:0] dstall_q, dstall_d;

    logic mem_busy;
    logic ld_use;

    // A data access still outstanding freezes everything; a load feeding a
    // decode-stage source needs one bubble (r0 is never a real dependency).
    assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;
    assign ld_use   = ex_dREN & (ex_wsel != 5'd0) &
                      ((ex_wsel == id_rs) | (ex_wsel == id_rt));

    // Next-state and zero-latency latch controls, highest-priority rule first.
    always_comb begin
        state_d       = state_q;
        dstall_d      = dstall_q;
        pc_en         = 1'b0;
        fetch_en      = 1'b0;
        fetch_flush   = 1'b0;
        decode_en     = 1'b0;
        decode_flush  = 1'b0;
        execute_en    = 1'b0;
        execute_flush = 1'b0;
        memory_en     = 1'b0;
        memory_flush  = 1'b0;

        // HALT, and an active reset, leave every control at zero.
        if (nRST && (state_q != HALT)) begin
            if (mem_busy) begin
                state_d = DWAIT;
                if (dstall_q != 16'hFFFF) begin
                    dstall_d = dstall_q + 16'd1;
                end
            end else if (mem_halt) begin
                // Let the halt instruction retire; squash everything younger.
                state_d       = HALT;
                fetch_en      = 1'b1;
                fetch_flush   = 1'b1;
                decode_en     = 1'b1;
                decode_flush  = 1'b1;
                execute_en    = 1'b1;
                execute_flush = 1'b1;
                memory_en     = 1'b1;
            end else if (mem_branch_taken | mem_jump) begin
                // Redirect the PC and squash the wrong-path instructions.
                state_d       = RUN;
                pc_en         = 1'b1;
                fetch_en      = 1'b1;
                fetch_flush   = 1'b1;
                decode_en     = 1'b1;
                decode_flush  = 1'b1;
                execute_en    = 1'b1;
                execute_flush = 1'b1;
                memory_en     = 1'b1;
            end else if (ld_use) begin
                // Hold PC and fetch latch, insert a bubble into execute.
                state_d      = RUN;
                decode_en    = 1'b1;
                decode_flush = 1'b1;
                execute_en   = 1'b1;
                memory_en    = 1'b1;
            end else if (!ihit) begin
                // Fetch not done: hold PC, push a bubble behind it.
                state_d     = RUN;
                fetch_en    = 1'b1;
                fetch_flush = 1'b1;
                decode_en   = 1'b1;
                execute_en  = 1'b1;
                memory_en   = 1'b1;
            end else begin
                state_d    = RUN;
                pc_en      = 1'b1;
                fetch_en   = 1'b1;
                decode_en  = 1'b1;
                execute_en = 1'b1;
                memory_en  = 1'b1;
            end
        end
    end

    // State, sticky halt flag and stall counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= RUN;
            halted_q <= 1'b0;
            dstall_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == HALT);
            dstall_q <= dstall_d;
        end
    end

    assign halted       = halted_q;
    assign dstall_count = dstall_q;

endmodule
